// File: rtl/kypd_pkg.sv
// kypd_pkg: shared types and key map for the PmodKYPD
// emulator and the keypad scanner decode.
package kypd_pkg;

    localparam logic [3:0] ROW_IDLE = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        B_PRESS,
        HOLD,
        B_REL,
        GAP
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rc_t;

    // Key code at each {row, col}; index 0 is row 0, column 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic rc_t key_to_rc(input logic [3:0] code);
        rc_t rc;
        rc = '0;
        unique case (code)
            4'h1: rc = 4'b00_00;
            4'h2: rc = 4'b00_01;
            4'h3: rc = 4'b00_10;
            4'hA: rc = 4'b00_11;
            4'h4: rc = 4'b01_00;
            4'h5: rc = 4'b01_01;
            4'h6: rc = 4'b01_10;
            4'hB: rc = 4'b01_11;
            4'h7: rc = 4'b10_00;
            4'h8: rc = 4'b10_01;
            4'h9: rc = 4'b10_10;
            4'hC: rc = 4'b10_11;
            4'h0: rc = 4'b11_00;
            4'hF: rc = 4'b11_01;
            4'hE: rc = 4'b11_10;
            4'hD: rc = 4'b11_11;
        endcase
        return rc;
    endfunction

    function automatic logic [3:0] rc_to_key(input rc_t rc);
        return KEY_MAP[{rc.row, rc.col}];
    endfunction

endpackage

// File: rtl/kypd_row_drive.sv
// kypd_row_drive: registered row response of the
// emulated keypad for the latched key position.
module kypd_row_drive
    import kypd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  rc_t        key_rc,
    input  logic       pressed,
    input  logic [3:0] col_n,
    output logic [3:0] row_n
);

    logic       col_hit;
    logic [3:0] row_nxt;

    // Closed contact pulls its row low while its column is strobed.
    always_comb begin
        col_hit = pressed && !col_n[~key_rc.col];
        row_nxt = ROW_IDLE;
        if (col_hit) begin
            row_nxt[~key_rc.row] = 1'b0;
        end
    end

    // Row pins answer one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_n <= ROW_IDLE;
        end else begin
            row_n <= row_nxt;
        end
    end

endmodule

// File: rtl/kypd_emulator.sv
// kypd_emulator: plays scripted key events as press,
// hold, release with contact bounce on a 4x4 keypad.
module kypd_emulator
    import kypd_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int HOLD_CYCLES   = 1_000_000,
    parameter int GAP_CYCLES    = 1_000_000,
    parameter int BOUNCE_CYCLES = 50_000,
    parameter int BOUNCE_PERIOD = 5_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic       abort,
    output logic       busy,
    output logic       pressed
);

    localparam int TOG_W =
        (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

    localparam logic [CNT_W-1:0] HOLD_LD =
        CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD =
        CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BNC_LD =
        CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [TOG_W-1:0] TOG_LD =
        TOG_W'(BOUNCE_PERIOD - 1);

    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES != 0);

    localparam longint CNT_MAX =
        (longint'(1) << CNT_W) - 1;

    if (longint'(HOLD_CYCLES) > CNT_MAX
        || longint'(GAP_CYCLES) > CNT_MAX
        || longint'(BOUNCE_CYCLES) > CNT_MAX
        || HOLD_CYCLES < 1
        || GAP_CYCLES < 1
        || BOUNCE_CYCLES < 0
        || BOUNCE_PERIOD < 1) begin : g_cfg_err
        $error("kypd_emulator: phase timing out of counter range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [TOG_W-1:0] tog;
    logic [TOG_W-1:0] tog_nxt;
    logic             pressed_nxt;
    rc_t              key_rc;
    rc_t              key_rc_nxt;

    logic             accept;
    logic             cnt_done;
    logic             tog_done;
    logic             can_abort;

    assign accept    = key_valid && key_ready;
    assign cnt_done  = (cnt == '0);
    assign tog_done  = (tog == '0);
    assign can_abort = (state == B_PRESS)
                    || (state == HOLD)
                    || (state == B_REL);

    // Phase state, counters, contact level and latched key.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tog     <= '0;
            pressed <= 1'b0;
            key_rc  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tog     <= tog_nxt;
            pressed <= pressed_nxt;
            key_rc  <= key_rc_nxt;
        end
    end

    // Phase sequencing; each phase loads N-1 and ends at zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tog_nxt     = tog;
        pressed_nxt = pressed;
        key_rc_nxt  = key_rc;
        unique case (state)
            IDLE: begin
                pressed_nxt = 1'b0;
                if (accept) begin
                    key_rc_nxt  = key_to_rc(key_code);
                    pressed_nxt = 1'b1;
                    tog_nxt     = TOG_LD;
                    if (HAS_BOUNCE) begin
                        state_nxt = B_PRESS;
                        cnt_nxt   = BNC_LD;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_LD;
                    end
                end
            end
            B_PRESS, B_REL: begin
                if (cnt_done) begin
                    if (state == B_PRESS) begin
                        state_nxt   = HOLD;
                        cnt_nxt     = HOLD_LD;
                        pressed_nxt = 1'b1;
                    end else begin
                        state_nxt   = GAP;
                        cnt_nxt     = GAP_LD;
                        pressed_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (tog_done) begin
                        tog_nxt     = TOG_LD;
                        pressed_nxt = !pressed;
                    end else begin
                        tog_nxt = tog - TOG_W'(1);
                    end
                end
            end
            HOLD: begin
                pressed_nxt = 1'b1;
                if (cnt_done) begin
                    pressed_nxt = 1'b0;
                    tog_nxt     = TOG_LD;
                    if (HAS_BOUNCE) begin
                        state_nxt = B_REL;
                        cnt_nxt   = BNC_LD;
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                pressed_nxt = 1'b0;
                if (cnt_done) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                pressed_nxt = 1'b0;
            end
        endcase
        if (abort && can_abort) begin
            state_nxt   = GAP;
            cnt_nxt     = GAP_LD;
            pressed_nxt = 1'b0;
        end
    end

    // Handshake and status decode of the current state.
    always_comb begin
        busy      = (state != IDLE);
        key_ready = rst && (state == IDLE) && !abort;
    end

    kypd_row_drive u_row_drive (
        .clk     (clk),
        .rst     (rst),
        .key_rc  (key_rc),
        .pressed (pressed),
        .col_n   (col_n),
        .row_n   (row_n)
    );

endmodule

// File: tb/tb_kypd_emulator.sv
// tb_kypd_emulator: self-checking bench for the keypad
// emulator, bounce and bounce-free builds.
`timescale 1ns/1ps
module tb_kypd_emulator;

    localparam int H = 20;
    localparam int G = 10;
    localparam int B = 6;
    localparam int P = 2;

    typedef struct {
        bit p;
        bit ab;
    } ph_t;

    typedef struct {
        logic [3:0] key;
        logic [3:0] col;
        logic [3:0] row;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       abort;
    logic [3:0] row_n;
    logic       key_ready;
    logic       busy;
    logic       pressed;

    logic [3:0] col_n_b;
    logic       key_valid_b;
    logic [3:0] key_code_b;
    logic       abort_b;
    logic [3:0] row_n_b;
    logic       key_ready_b;
    logic       busy_b;
    logic       pressed_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk = 1'b0;

    ph_t        q[$];
    int         m_r = 0;
    int         m_c = 0;
    logic [3:0] m_row = 4'hF;
    bit         m_acc = 1'b0;

    logic [3:0] s_row;
    logic       s_p;
    logic       s_busy;
    logic       s_ready;
    logic [3:0] sb_row;
    logic       sb_p;
    logic       sb_busy;
    logic       sb_ready;

    byte unsigned lay [16] = '{
        1, 2, 3, 10,
        4, 5, 6, 11,
        7, 8, 9, 12,
        0, 15, 14, 13
    };

    logic [3:0] rot [4] = '{
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    kypd_emulator #(
        .CNT_W         (8),
        .HOLD_CYCLES   (H),
        .GAP_CYCLES    (G),
        .BOUNCE_CYCLES (B),
        .BOUNCE_PERIOD (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .abort     (abort),
        .busy      (busy),
        .pressed   (pressed)
    );

    kypd_emulator #(
        .CNT_W         (8),
        .HOLD_CYCLES   (H),
        .GAP_CYCLES    (G),
        .BOUNCE_CYCLES (0),
        .BOUNCE_PERIOD (P)
    ) dut_nb (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n_b),
        .row_n     (row_n_b),
        .key_valid (key_valid_b),
        .key_code  (key_code_b),
        .key_ready (key_ready_b),
        .abort     (abort_b),
        .busy      (busy_b),
        .pressed   (pressed_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Reference: a key is a list of per-cycle contact levels.
    task automatic model_edge();
        bit cur_p;
        cur_p = (q.size() != 0) ? q[0].p : 1'b0;
        m_acc = 1'b0;
        m_row = 4'hF;
        if (rst && cur_p && !col_n[3 - m_c])
            m_row[3 - m_r] = 1'b0;
        if (!rst) begin
            q.delete();
        end else if (q.size() != 0) begin
            if (abort && q[0].ab) begin
                q.delete();
                for (int i = 0; i < G; i++)
                    q.push_back('{1'b0, 1'b0});
            end else begin
                void'(q.pop_front());
            end
        end else if (key_valid && !abort) begin
            for (int i = 0; i < 16; i++)
                if (lay[i] == key_code) begin
                    m_r = i / 4;
                    m_c = i % 4;
                end
            for (int k = 0; k < B; k++)
                q.push_back('{((k / P) % 2) == 0, 1'b1});
            for (int k = 0; k < H; k++)
                q.push_back('{1'b1, 1'b1});
            for (int k = 0; k < B; k++)
                q.push_back('{((k / P) % 2) == 1, 1'b1});
            for (int k = 0; k < G; k++)
                q.push_back('{1'b0, 1'b0});
            m_acc = 1'b1;
        end
    endtask

    task automatic cyc();
        bit ep;
        @(negedge clk);
        s_row    = row_n;
        s_p      = pressed;
        s_busy   = busy;
        s_ready  = key_ready;
        sb_row   = row_n_b;
        sb_p     = pressed_b;
        sb_busy  = busy_b;
        sb_ready = key_ready_b;
        if (chk) begin
            ep = (q.size() != 0) ? q[0].p : 1'b0;
            cmp("row_n", s_row, m_row);
            cmp("pressed", s_p, ep);
            cmp("busy", s_busy, q.size() != 0);
            cmp("key_ready", s_ready,
                rst && q.size() == 0 && !abort);
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, %0d compared",
                 n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [16];
        logic [41:0] exp_tr;
        logic [41:0] act_tr;
        logic [3:0] prev;
        logic [3:0] dec[$];
        int         cnt_a;
        int         cnt_b;
        int         cnt_c;
        int         acc1;
        int         acc2;
        int         last_det;
        int         rr;
        int         cc;

        tbl[0]  = '{4'h5, 4'b1011, 4'b1011};
        tbl[1]  = '{4'h5, 4'b0111, 4'b1111};
        tbl[2]  = '{4'h5, 4'b0000, 4'b1011};
        tbl[3]  = '{4'hD, 4'b1110, 4'b1110};
        tbl[4]  = '{4'hD, 4'b1101, 4'b1111};
        tbl[5]  = '{4'h0, 4'b0111, 4'b1110};
        tbl[6]  = '{4'h1, 4'b0111, 4'b0111};
        tbl[7]  = '{4'hA, 4'b1110, 4'b0111};
        tbl[8]  = '{4'hE, 4'b1101, 4'b1110};
        tbl[9]  = '{4'h9, 4'b1101, 4'b1101};
        tbl[10] = '{4'hC, 4'b1110, 4'b1101};
        tbl[11] = '{4'h4, 4'b0111, 4'b1011};
        tbl[12] = '{4'hF, 4'b1011, 4'b1110};
        tbl[13] = '{4'h7, 4'b0111, 4'b1101};
        tbl[14] = '{4'h3, 4'b1101, 4'b0111};
        tbl[15] = '{4'h2, 4'b1111, 4'b1111};

        rst = 1'b0;
        col_n = 4'hF;
        key_valid = 1'b0;
        key_code = 4'h0;
        abort = 1'b0;
        col_n_b = 4'hF;
        key_valid_b = 1'b0;
        key_code_b = 4'h0;
        abort_b = 1'b0;

        // reset state
        @(posedge clk);
        #1;
        chk = 1'b1;
        q.delete();
        m_row = 4'hF;
        cyc();
        cmp("rst_ready", s_ready, 1'b0);
        cmp("rst_ready_b", sb_ready, 1'b0);
        cmp("rst_busy_b", sb_busy, 1'b0);
        cmp("rst_pressed_b", sb_p, 1'b0);
        cmp("rst_row_b", sb_row, 4'hF);

        // key 5 with bounce, key 0 on the bounce-free build
        rst = 1'b1;
        key_code = 4'h5;
        key_valid = 1'b1;
        col_n = 4'b1011;
        key_code_b = 4'h0;
        key_valid_b = 1'b1;
        col_n_b = 4'b0111;
        cyc();
        cmp("t1_ready", s_ready, 1'b1);
        cmp("t3_ready_b", sb_ready, 1'b1);
        key_valid = 1'b0;
        key_valid_b = 1'b0;
        exp_tr = {6'b110011, {20{1'b1}}, 6'b001100, 10'b0};
        act_tr = '0;
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        for (int i = 0; i < 42; i++) begin
            cyc();
            act_tr[41 - i] = s_p;
            if (s_row == 4'b1011) cnt_a++;
            if (sb_row == 4'b1110) cnt_b++;
            if (sb_busy) cnt_c++;
        end
        cmp("t1_trace", act_tr, exp_tr);
        cmp("t1_row_cycles", cnt_a, 26);
        cmp("t3_row_cycles", cnt_b, 20);
        cmp("t3_busy_cycles", cnt_c, 30);
        cyc();
        cmp("t1_idle_busy", s_busy, 1'b0);
        cmp("t1_idle_ready", s_ready, 1'b1);

        // key D under a rotating column scan
        key_code = 4'hD;
        key_valid = 1'b1;
        col_n = rot[0];
        cyc();
        key_valid = 1'b0;
        cnt_a = 0;
        for (int i = 1; i <= 44; i++) begin
            col_n = rot[i % 4];
            cyc();
            if (s_row == 4'b1110) cnt_a++;
        end
        cmp("t2_hits", cnt_a, 5);

        // abort in HOLD, then abort against key_valid in IDLE
        key_code = 4'h2;
        key_valid = 1'b1;
        col_n = 4'b1011;
        cyc();
        key_valid = 1'b0;
        for (int i = 1; i <= 10; i++) cyc();
        abort = 1'b1;
        cyc();
        cyc();
        cmp("t4_pressed", s_p, 1'b0);
        cmp("t4_busy", s_busy, 1'b1);
        abort = 1'b0;
        cnt_a = 1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (!s_busy) break;
            cnt_a++;
        end
        cmp("t4_gap", cnt_a, G);
        cmp("t4_ready", s_ready, 1'b1);
        abort = 1'b1;
        key_valid = 1'b1;
        key_code = 4'h3;
        cyc();
        cmp("t4_abort_ready", s_ready, 1'b0);
        abort = 1'b0;
        key_valid = 1'b0;
        cyc();
        cmp("t4_not_taken", s_busy, 1'b0);

        // back-to-back A then F, decoded by a scanner
        acc1 = -1;
        acc2 = -1;
        last_det = -100;
        dec.delete();
        key_code = 4'hA;
        key_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            prev = col_n;
            col_n = rot[i % 4];
            cyc();
            if (s_row != 4'hF) begin
                rr = 0;
                cc = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!s_row[3 - k]) rr = k;
                    if (!prev[3 - k]) cc = k;
                end
                if (i - last_det > 12)
                    dec.push_back(4'(lay[rr * 4 + cc]));
                last_det = i;
            end
            if (m_acc) begin
                if (acc1 < 0) begin
                    acc1 = i;
                    key_code = 4'hF;
                end else begin
                    acc2 = i;
                    key_valid = 1'b0;
                end
            end
            if (acc2 >= 0 && i >= acc2 + 50) break;
        end
        key_valid = 1'b0;
        cmp("t5_spacing", acc2 - acc1, 43);
        cmp("t5_count", dec.size(), 2);
        if (dec.size() >= 2) begin
            cmp("t5_first", dec[0], 4'hA);
            cmp("t5_second", dec[1], 4'hF);
        end

        // reset in HOLD of key 7
        key_code = 4'h7;
        key_valid = 1'b1;
        col_n = 4'b0111;
        cyc();
        key_valid = 1'b0;
        for (int i = 1; i <= 9; i++) cyc();
        cmp("t6_row_hold", s_row, 4'b1101);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        cmp("t6_row", s_row, 4'hF);
        cmp("t6_pressed", s_p, 1'b0);
        cmp("t6_busy", s_busy, 1'b0);
        cmp("t6_ready", s_ready, 1'b1);

        // key map table
        for (int i = 0; i < 16; i++) begin
            col_n = tbl[i].col;
            key_code = tbl[i].key;
            key_valid = 1'b1;
            cyc();
            key_valid = 1'b0;
            for (int j = 1; j <= 14; j++) cyc();
            cmp($sformatf("tbl_row_%h_%b", tbl[i].key, tbl[i].col),
                s_row, tbl[i].row);
            for (int j = 15; j <= 44; j++) cyc();
        end

        // randomized traffic against the reference
        for (int n = 0; n < 1500; n++) begin
            if (!key_valid && $urandom_range(0, 3) == 0) begin
                key_valid = 1'b1;
                key_code = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 2) == 0)
                col_n = 4'($urandom_range(0, 15));
            else
                col_n = rot[$urandom_range(0, 3)];
            abort = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) != 0);
            cyc();
            if (m_acc) key_valid = 1'b0;
        end
        rst = 1'b1;
        abort = 1'b0;
        key_valid = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
